// File: rtl/tx_pkt_sequencer.sv
// tx_pkt_sequencer
//   Sequences one USB full-speed transmit packet: SYNC, PID, optional payload
//   with CRC16, then EOP. It drives the bit timer and shift-register load
//   strobe, pops payload bytes from the tx FIFO and accumulates the CRC16.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 packet request (sampled only while idle)
//   i_pkt_data              1 = data packet, 0 = handshake (PID only)
//   i_pid, i_data_len       PID nibble and payload byte count, sampled with i_start
//   i_abort                 abandon the packet and go straight to EOP
//   i_fifo_rdata/empty      head-of-FIFO byte and empty flag
//   o_fifo_pop              one-cycle pop strobe
//   i_shift_strobe          bit-period strobe from the timer
//   i_byte_complete         eighth-bit strobe from the timer
//   o_enable_timer          timer count enable
//   o_clear_timer           one-cycle timer / bit-counter clear
//   o_load_en, o_load_byte  shift-register load strobe and byte (LSB sent first)
//   o_send_eop              drive SE0 on the line
//   o_busy                  packet in progress
//   o_tx_done, o_tx_error   one-cycle completion / failure pulses
//
// Every output is a register, so each reaction is visible one cycle after the
// input that caused it.

module tx_pkt_sequencer #(
  parameter int LEN_W    = 7,
  parameter int EOP_BITS = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_pkt_data,
  input  logic [3:0]       i_pid,
  input  logic [LEN_W-1:0] i_data_len,
  input  logic             i_abort,
  input  logic [7:0]       i_fifo_rdata,
  input  logic             i_fifo_empty,
  output logic             o_fifo_pop,
  input  logic             i_shift_strobe,
  input  logic             i_byte_complete,
  output logic             o_enable_timer,
  output logic             o_clear_timer,
  output logic             o_load_en,
  output logic [7:0]       o_load_byte,
  output logic             o_send_eop,
  output logic             o_busy,
  output logic             o_tx_done,
  output logic             o_tx_error
);

  localparam int            EW       = $clog2(EOP_BITS + 1);
  localparam logic [EW-1:0] EOP_LAST = EW'(EOP_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP, S_DONE
  } state_t;

  state_t           r_state, w_state_next;
  logic [3:0]       r_pid, w_pid_next;
  logic             r_pkt_data, w_pkt_data_next;
  logic [LEN_W-1:0] r_len, w_len_next;
  logic [LEN_W-1:0] r_cnt, w_cnt_next;
  logic [15:0]      r_crc, w_crc_next;
  logic             r_err, w_err_next;
  logic [EW-1:0]    r_eop_cnt, w_eop_cnt_next;

  logic             r_fifo_pop, w_fifo_pop_next;
  logic             r_enable_timer, w_enable_timer_next;
  logic             r_clear_timer, w_clear_timer_next;
  logic             r_load_en, w_load_en_next;
  logic [7:0]       r_load_byte, w_load_byte_next;
  logic             r_send_eop, w_send_eop_next;
  logic             r_busy, w_busy_next;
  logic             r_tx_done, w_tx_done_next;
  logic             r_tx_error, w_tx_error_next;

  logic             w_in_body;
  logic             w_need_byte;

  // CRC16 (reflected 0xA001) advanced by one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
    end
    return x;
  endfunction

  always_comb begin
    w_state_next       = r_state;
    w_pid_next         = r_pid;
    w_pkt_data_next    = r_pkt_data;
    w_len_next         = r_len;
    w_cnt_next         = r_cnt;
    w_crc_next         = r_crc;
    w_err_next         = r_err;
    w_eop_cnt_next     = r_eop_cnt;
    w_fifo_pop_next    = 1'b0;
    w_clear_timer_next = 1'b0;
    w_load_en_next     = 1'b0;
    w_load_byte_next   = r_load_byte;
    w_tx_done_next     = 1'b0;
    w_tx_error_next    = 1'b0;
    w_need_byte        = 1'b0;

    w_in_body = (r_state inside {S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI});

    // Abort takes priority over a coincident byte_complete, so no pop or load.
    if (w_in_body && i_abort) begin
      w_err_next      = 1'b1;
      w_tx_error_next = 1'b1;
      w_state_next    = S_EOP;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_pid_next         = i_pid;
            w_pkt_data_next    = i_pkt_data;
            w_len_next         = i_data_len;
            w_cnt_next         = '0;
            w_crc_next         = 16'hFFFF;
            w_err_next         = 1'b0;
            w_clear_timer_next = 1'b1;
            w_load_en_next     = 1'b1;
            w_load_byte_next   = 8'h80;
            w_state_next       = S_SYNC;
          end
        end
        S_SYNC: begin
          if (i_byte_complete) begin
            w_load_en_next   = 1'b1;
            w_load_byte_next = {~r_pid, r_pid};
            w_state_next     = S_PID;
          end
        end
        S_PID: begin
          if (i_byte_complete) begin
            if (!r_pkt_data) begin
              w_state_next = S_EOP;
            end else if (r_len == '0) begin
              w_load_en_next   = 1'b1;
              w_load_byte_next = ~r_crc[7:0];
              w_state_next     = S_CRC_LO;
            end else begin
              w_need_byte = 1'b1;
            end
          end
        end
        S_DATA: begin
          if (i_byte_complete) begin
            if (r_cnt == r_len) begin
              // r_crc already includes the last popped byte here.
              w_load_en_next   = 1'b1;
              w_load_byte_next = ~r_crc[7:0];
              w_state_next     = S_CRC_LO;
            end else begin
              w_need_byte = 1'b1;
            end
          end
        end
        S_CRC_LO: begin
          if (i_byte_complete) begin
            w_load_en_next   = 1'b1;
            w_load_byte_next = ~r_crc[15:8];
            w_state_next     = S_CRC_HI;
          end
        end
        S_CRC_HI: begin
          if (i_byte_complete) begin
            w_state_next = S_EOP;
          end
        end
        S_EOP: begin
          // EOP_BITS strobes of SE0, then one more strobe of J before DONE.
          if (i_shift_strobe) begin
            if (r_eop_cnt == EOP_LAST) begin
              w_state_next   = S_DONE;
              w_tx_done_next = !r_err;
            end else begin
              w_eop_cnt_next = r_eop_cnt + EW'(1);
            end
          end
        end
        S_DONE: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase

      // Shared payload fetch for the first and subsequent data bytes.
      if (w_need_byte) begin
        if (!i_fifo_empty) begin
          w_fifo_pop_next  = 1'b1;
          w_load_en_next   = 1'b1;
          w_load_byte_next = i_fifo_rdata;
          w_crc_next       = crc16_byte(r_crc, i_fifo_rdata);
          w_cnt_next       = r_cnt + LEN_W'(1);
          w_state_next     = S_DATA;
        end else begin
          w_err_next      = 1'b1;
          w_tx_error_next = 1'b1;
          w_state_next    = S_EOP;
        end
      end
    end

    // The EOP bit counter restarts on every entry into EOP.
    if (r_state != S_EOP) begin
      w_eop_cnt_next = '0;
    end

    w_enable_timer_next = (w_state_next inside {S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP});
    w_busy_next         = (w_state_next != S_IDLE);
    w_send_eop_next     = (w_state_next == S_EOP) && (w_eop_cnt_next != EOP_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_pid          <= 4'h0;
      r_pkt_data     <= 1'b0;
      r_len          <= '0;
      r_cnt          <= '0;
      r_crc          <= 16'hFFFF;
      r_err          <= 1'b0;
      r_eop_cnt      <= '0;
      r_fifo_pop     <= 1'b0;
      r_enable_timer <= 1'b0;
      r_clear_timer  <= 1'b0;
      r_load_en      <= 1'b0;
      r_load_byte    <= 8'h00;
      r_send_eop     <= 1'b0;
      r_busy         <= 1'b0;
      r_tx_done      <= 1'b0;
      r_tx_error     <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pid          <= w_pid_next;
      r_pkt_data     <= w_pkt_data_next;
      r_len          <= w_len_next;
      r_cnt          <= w_cnt_next;
      r_crc          <= w_crc_next;
      r_err          <= w_err_next;
      r_eop_cnt      <= w_eop_cnt_next;
      r_fifo_pop     <= w_fifo_pop_next;
      r_enable_timer <= w_enable_timer_next;
      r_clear_timer  <= w_clear_timer_next;
      r_load_en      <= w_load_en_next;
      r_load_byte    <= w_load_byte_next;
      r_send_eop     <= w_send_eop_next;
      r_busy         <= w_busy_next;
      r_tx_done      <= w_tx_done_next;
      r_tx_error     <= w_tx_error_next;
    end
  end

  assign o_fifo_pop     = r_fifo_pop;
  assign o_enable_timer = r_enable_timer;
  assign o_clear_timer  = r_clear_timer;
  assign o_load_en      = r_load_en;
  assign o_load_byte    = r_load_byte;
  assign o_send_eop     = r_send_eop;
  assign o_busy         = r_busy;
  assign o_tx_done      = r_tx_done;
  assign o_tx_error     = r_tx_error;

endmodule

// File: tb/tb_tx_pkt_sequencer.sv
// tb_tx_pkt_sequencer
//   Directed bench for tx_pkt_sequencer: handshake, zero-length data, two-byte
//   data with CRC, FIFO underrun, abort with a stray start, and reset mid-packet.
//   A small FIFO and a bit-timer stimulus task feed the design; a negedge
//   monitor logs every load, pop and status pulse.

module tb_tx_pkt_sequencer;

  localparam int LEN_W = 7;

  logic             clk = 1'b0;
  logic             rst, start, pkt_data, abort, shift_strobe, byte_complete;
  logic [3:0]       pid;
  logic [LEN_W-1:0] data_len;
  logic [7:0]       fifo_rdata;
  logic             fifo_empty;
  logic             fifo_pop, enable_timer, clear_timer, load_en, send_eop;
  logic             busy, tx_done, tx_error;
  logic [7:0]       load_byte;

  always #5 clk = ~clk;

  tx_pkt_sequencer #(.LEN_W(LEN_W), .EOP_BITS(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pkt_data(pkt_data),
    .i_pid(pid), .i_data_len(data_len), .i_abort(abort),
    .i_fifo_rdata(fifo_rdata), .i_fifo_empty(fifo_empty), .o_fifo_pop(fifo_pop),
    .i_shift_strobe(shift_strobe), .i_byte_complete(byte_complete),
    .o_enable_timer(enable_timer), .o_clear_timer(clear_timer),
    .o_load_en(load_en), .o_load_byte(load_byte), .o_send_eop(send_eop),
    .o_busy(busy), .o_tx_done(tx_done), .o_tx_error(tx_error)
  );

  // ---------------- FIFO model ----------------
  logic [7:0] fifo_mem [0:63];
  int         wr_cnt = 0;
  int         rd_ptr = 0;
  assign fifo_empty = (rd_ptr >= wr_cnt);
  assign fifo_rdata = fifo_mem[rd_ptr[5:0]];

  // ---------------- monitor ----------------
  logic [7:0] loads[$];
  int  pops = 0, dones = 0, errs = 0, eops = 0, js = 0, clears = 0;
  bit  in_eop = 1'b0;

  always @(negedge clk) begin
    if (load_en) loads.push_back(load_byte);
    if (fifo_pop) begin
      pops   <= pops + 1;
      rd_ptr <= rd_ptr + 1;
    end
    if (tx_done)     dones  <= dones + 1;
    if (tx_error)    errs   <= errs + 1;
    if (clear_timer) clears <= clears + 1;
    if (shift_strobe && busy) begin
      if (send_eop)    eops <= eops + 1;
      else if (in_eop) js   <= js + 1;
    end
    in_eop <= busy && (in_eop || send_eop);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  int b_ld, b_pop, b_done, b_err, b_eop, b_j, b_clr;

  task automatic snap();
    b_ld = loads.size(); b_pop = pops; b_done = dones; b_err = errs;
    b_eop = eops; b_j = js; b_clr = clears;
  endtask

  function automatic logic [7:0] ld(input int idx);
    return (idx < loads.size()) ? loads[idx] : 8'hXX;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fifo_push(input logic [7:0] b);
    fifo_mem[wr_cnt[5:0]] = b;
    wr_cnt++;
  endtask

  task automatic send_start(input logic pd, input logic [3:0] p, input logic [LEN_W-1:0] n);
    cyc(1);
    start = 1'b1; pkt_data = pd; pid = p; data_len = n;
    cyc(1);
    start = 1'b0;
  endtask

  // Bit timer: one strobe every 3 cycles, byte_complete on every 8th strobe.
  task automatic run_timer(input int budget);
    int used  = 0;
    int bit_i = 0;
    while (busy && used < budget) begin
      cyc(2);
      if (!busy) break;
      shift_strobe  = 1'b1;
      byte_complete = (bit_i == 7);
      bit_i = (bit_i + 1) % 8;
      cyc(1);
      shift_strobe  = 1'b0;
      byte_complete = 1'b0;
      used++;
    end
    check("timer_bound_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_loads(input int n);
    int w = 0;
    while (loads.size() < n && w < 2000) begin
      cyc(1);
      w++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int la, pa;
    rst = 1'b1; start = 1'b0; pkt_data = 1'b0; pid = 4'h0; data_len = '0;
    abort = 1'b0; shift_strobe = 1'b0; byte_complete = 1'b0;
    cyc(3);
    check("rst_busy",      {31'd0, busy},         32'd0);
    check("rst_enable",    {31'd0, enable_timer}, 32'd0);
    check("rst_load_byte", {24'd0, load_byte},    32'd0);
    check("rst_misc", {26'd0, load_en, clear_timer, send_eop, fifo_pop, tx_done, tx_error}, 32'd0);
    rst = 1'b0;
    cyc(2);

    // ---- handshake, PID 2 ----
    snap();
    send_start(1'b0, 4'h2, LEN_W'(0));
    check("hs_clear",   {31'd0, clear_timer},  32'd1);
    check("hs_load_en", {31'd0, load_en},      32'd1);
    check("hs_sync",    {24'd0, load_byte},    32'h80);
    check("hs_enable",  {31'd0, enable_timer}, 32'd1);
    check("hs_busy",    {31'd0, busy},         32'd1);
    run_timer(200);
    cyc(2);
    check("hs_nloads", loads.size() - b_ld, 2);
    check("hs_pid",    {24'd0, ld(b_ld + 1)}, 32'hD2);
    check("hs_se0",    eops - b_eop, 2);
    check("hs_j",      js - b_j, 1);
    check("hs_done",   dones - b_done, 1);
    check("hs_err",    errs - b_err, 0);
    check("hs_pops",   pops - b_pop, 0);
    check("hs_idle_en", {31'd0, enable_timer}, 32'd0);

    // ---- data, len 0 ----
    snap();
    send_start(1'b1, 4'h3, LEN_W'(0));
    run_timer(300);
    cyc(2);
    check("z_nloads", loads.size() - b_ld, 4);
    check("z_pid",    {24'd0, ld(b_ld + 1)}, 32'hC3);
    check("z_crclo",  {24'd0, ld(b_ld + 2)}, 32'h00);
    check("z_crchi",  {24'd0, ld(b_ld + 3)}, 32'h00);
    check("z_pops",   pops - b_pop, 0);
    check("z_done",   dones - b_done, 1);

    // ---- data, len 2: 01 02 -> CRC 7E 1E ----
    snap();
    fifo_push(8'h01); fifo_push(8'h02);
    send_start(1'b1, 4'h3, LEN_W'(2));
    run_timer(400);
    cyc(2);
    check("d2_nloads", loads.size() - b_ld, 6);
    check("d2_b0",     {24'd0, ld(b_ld + 2)}, 32'h01);
    check("d2_b1",     {24'd0, ld(b_ld + 3)}, 32'h02);
    check("d2_crclo",  {24'd0, ld(b_ld + 4)}, 32'h7E);
    check("d2_crchi",  {24'd0, ld(b_ld + 5)}, 32'h1E);
    check("d2_pops",   pops - b_pop, 2);
    check("d2_done",   dones - b_done, 1);
    check("d2_err",    errs - b_err, 0);

    // ---- underrun: len 3, FIFO holds one byte ----
    snap();
    fifo_push(8'hAA);
    send_start(1'b1, 4'h3, LEN_W'(3));
    run_timer(400);
    cyc(2);
    check("ur_nloads", loads.size() - b_ld, 3);
    check("ur_b0",     {24'd0, ld(b_ld + 2)}, 32'hAA);
    check("ur_pops",   pops - b_pop, 1);
    check("ur_err",    errs - b_err, 1);
    check("ur_done",   dones - b_done, 0);
    check("ur_se0",    eops - b_eop, 2);

    // ---- abort in DATA, then a start while the packet winds down ----
    snap();
    fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33);
    send_start(1'b1, 4'h3, LEN_W'(3));
    la = 0;
    pa = 0;
    fork
      run_timer(400);
      begin
        wait_loads(b_ld + 3);
        check("ab_in_data", {31'd0, loads.size() >= b_ld + 3}, 32'd1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("ab_send_eop", {31'd0, send_eop}, 32'd1);
        check("ab_tx_error", {31'd0, tx_error}, 32'd1);
        la = loads.size();
        pa = pops;
        start = 1'b1; pkt_data = 1'b0; pid = 4'h2;
        cyc(1);
        start = 1'b0;
      end
    join
    cyc(5);
    check("ab_no_more_loads", loads.size() - la, 0);
    check("ab_no_more_pops",  pops - pa, 0);
    check("ab_pops",          pops - b_pop, 1);
    check("ab_done",          dones - b_done, 0);
    check("ab_err",           errs - b_err, 1);
    check("ab_start_ignored", {31'd0, busy}, 32'd0);
    check("ab_one_clear",     clears - b_clr, 1);
    wr_cnt = rd_ptr;

    // ---- reset while in DATA, then a clean handshake ----
    snap();
    fifo_push(8'h44); fifo_push(8'h55); fifo_push(8'h66);
    send_start(1'b1, 4'h3, LEN_W'(3));
    fork
      run_timer(400);
      begin
        wait_loads(b_ld + 3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rd_busy",      {31'd0, busy},         32'd0);
        check("rd_enable",    {31'd0, enable_timer}, 32'd0);
        check("rd_load_byte", {24'd0, load_byte},    32'd0);
        check("rd_misc", {26'd0, load_en, clear_timer, send_eop, fifo_pop, tx_done, tx_error}, 32'd0);
      end
    join
    cyc(2);
    wr_cnt = rd_ptr;
    snap();
    send_start(1'b0, 4'hA, LEN_W'(0));
    run_timer(200);
    cyc(2);
    check("rn_nloads", loads.size() - b_ld, 2);
    check("rn_sync",   {24'd0, ld(b_ld)},     32'h80);
    check("rn_pid",    {24'd0, ld(b_ld + 1)}, 32'h5A);
    check("rn_done",   dones - b_done, 1);
    check("rn_err",    errs - b_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
